// File: rtl/acl_command_arbiter.sv
// Two-requester round-robin arbiter in front of the PMOD ACL2 driver command port.
// Soft-reset requests win arbitration; a watchdog aborts stalled driver handshakes.
module acl_command_arbiter #(
    parameter int unsigned PARM_TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rst_20mhz,
    input  logic       i_acl_command_ready,
    input  logic       i_a_cmd_valid,
    input  logic [2:0] i_a_cmd,
    input  logic       i_b_cmd_valid,
    input  logic [2:0] i_b_cmd,
    output logic       o_a_cmd_done,
    output logic       o_b_cmd_done,
    output logic       o_a_cmd_err,
    output logic       o_b_cmd_err,
    output logic       o_acl_cmd_init_measur_mode,
    output logic       o_acl_cmd_start_measur_mode,
    output logic       o_acl_cmd_init_linked_mode,
    output logic       o_acl_cmd_start_linked_mode,
    output logic       o_acl_cmd_soft_reset,
    output logic       o_grant_b,
    output logic       o_busy,
    output logic       o_timeout_err
);

    localparam logic [2:0]  CMD_SOFT_RESET = 3'd5;
    localparam logic [23:0] WDOG_LAST      = 24'(PARM_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_DONE, S_RST_HOLD, S_DONE, S_RECOVER
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] cmd;
    } req_t;

    // One-hot driver level per command code: {soft_rst, start_lnk, init_lnk, start_meas, init_meas}
    function automatic logic [4:0] cmd_level(input logic [2:0] cmd);
        case (cmd)
            3'd1:    cmd_level = 5'b00001;
            3'd2:    cmd_level = 5'b00010;
            3'd3:    cmd_level = 5'b00100;
            3'd4:    cmd_level = 5'b01000;
            3'd5:    cmd_level = 5'b10000;
            default: cmd_level = 5'b00000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cmd_q, cmd_d;
    logic        grant_b_q, grant_b_d;
    logic        last_b_q, last_b_d;
    logic        err_flag_q, err_flag_d;
    logic [23:0] wdog_q, wdog_d;
    logic [4:0]  lvl_q, lvl_d;
    logic        done_a_q, done_a_d, done_b_q, done_b_d;
    logic        err_a_q, err_a_d, err_b_q, err_b_d;
    logic        busy_q, busy_d;
    logic        tmo_q, tmo_d;

    req_t        req_a, req_b;
    logic        a_soft, b_soft, win_b, go_done, timeout, wdog_expired;
    logic [2:0]  win_cmd;

    assign req_a = '{valid: i_a_cmd_valid, cmd: i_a_cmd};
    assign req_b = '{valid: i_b_cmd_valid, cmd: i_b_cmd};
    assign a_soft = req_a.valid && (req_a.cmd == CMD_SOFT_RESET);
    assign b_soft = req_b.valid && (req_b.cmd == CMD_SOFT_RESET);
    assign wdog_expired = (wdog_q == WDOG_LAST);

    // Soft reset outranks ordinary commands; equal rank goes to whoever was not served last.
    always_comb begin
        win_b = req_b.valid;
        if (a_soft != b_soft)
            win_b = b_soft;
        else if (req_a.valid && req_b.valid)
            win_b = !last_b_q;
        win_cmd = win_b ? req_b.cmd : req_a.cmd;
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        grant_b_d  = grant_b_q;
        last_b_d   = last_b_q;
        err_flag_d = err_flag_q;
        wdog_d     = wdog_q + 24'd1;
        lvl_d      = '0;
        done_a_d   = 1'b0;
        done_b_d   = 1'b0;
        err_a_d    = 1'b0;
        err_b_d    = 1'b0;
        tmo_d      = tmo_q;
        go_done    = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            S_IDLE: begin
                wdog_d = '0;
                if (i_acl_command_ready && (req_a.valid || req_b.valid)) begin
                    grant_b_d  = win_b;
                    last_b_d   = win_b;
                    cmd_d      = win_cmd;
                    err_flag_d = 1'b0;
                    if (win_cmd == CMD_SOFT_RESET) begin
                        state_d = S_RST_HOLD;
                        lvl_d   = cmd_level(win_cmd);
                    end else if (win_cmd != 3'd0 && win_cmd < CMD_SOFT_RESET) begin
                        state_d = S_ISSUE;
                        lvl_d   = cmd_level(win_cmd);
                    end else begin
                        err_flag_d = 1'b1;
                        go_done    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (!i_acl_command_ready) begin
                    state_d = S_WAIT_DONE;
                    wdog_d  = '0;
                end else if (wdog_expired) begin
                    timeout = 1'b1;
                end else begin
                    lvl_d = cmd_level(cmd_q);
                end
            end
            S_WAIT_DONE: begin
                if (i_acl_command_ready)
                    go_done = 1'b1;
                else if (wdog_expired)
                    timeout = 1'b1;
            end
            S_RST_HOLD: begin
                // Nonzero count guarantees the level was held for at least two cycles.
                if (i_acl_command_ready && wdog_q != '0)
                    go_done = 1'b1;
                else if (wdog_expired)
                    timeout = 1'b1;
                else
                    lvl_d = cmd_level(CMD_SOFT_RESET);
            end
            S_DONE: begin
                state_d = S_IDLE;
                wdog_d  = '0;
            end
            S_RECOVER: begin
                wdog_d = '0;
                if (i_acl_command_ready)
                    go_done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                wdog_d  = '0;
            end
        endcase

        if (timeout) begin
            tmo_d      = 1'b1;
            err_flag_d = 1'b1;
            lvl_d      = '0;
            if (i_acl_command_ready)
                go_done = 1'b1;
            else
                state_d = S_RECOVER;
        end

        if (go_done) begin
            state_d  = S_DONE;
            done_a_d = !grant_b_d;
            done_b_d = grant_b_d;
            err_a_d  = !grant_b_d && err_flag_d;
            err_b_d  = grant_b_d && err_flag_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            grant_b_q  <= 1'b0;
            last_b_q   <= 1'b1;
            err_flag_q <= 1'b0;
            wdog_q     <= '0;
            lvl_q      <= '0;
            done_a_q   <= 1'b0;
            done_b_q   <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            grant_b_q  <= grant_b_d;
            last_b_q   <= last_b_d;
            err_flag_q <= err_flag_d;
            wdog_q     <= wdog_d;
            lvl_q      <= lvl_d;
            done_a_q   <= done_a_d;
            done_b_q   <= done_b_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_acl_cmd_init_measur_mode  = lvl_q[0];
    assign o_acl_cmd_start_measur_mode = lvl_q[1];
    assign o_acl_cmd_init_linked_mode  = lvl_q[2];
    assign o_acl_cmd_start_linked_mode = lvl_q[3];
    assign o_acl_cmd_soft_reset        = lvl_q[4];
    assign o_a_cmd_done                = done_a_q;
    assign o_b_cmd_done                = done_b_q;
    assign o_a_cmd_err                 = err_a_q;
    assign o_b_cmd_err                 = err_b_q;
    assign o_grant_b                   = grant_b_q;
    assign o_busy                      = busy_q;
    assign o_timeout_err               = tmo_q;

endmodule

// File: tb/tb_acl_command_arbiter.sv
// Bench for acl_command_arbiter: driver-response profiles and requester patterns,
// expectations derived per transaction from the arbitration and handshake rules.
module tb_acl_command_arbiter;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b1;
    logic a_valid = 1'b0, b_valid = 1'b0;
    logic [2:0] a_cmd = '0, b_cmd = '0;
    logic a_done, b_done, a_err, b_err;
    logic l_im, l_sm, l_il, l_sl, l_sr;
    logic grant_b, busy, tmo_err;

    int total = 0;
    int bad = 0;

    bit ref_last_b = 1'b1;
    bit ref_grant = 1'b0;
    bit ref_tmo = 1'b0;
    bit rdy [64];

    acl_command_arbiter #(.PARM_TIMEOUT_CYCLES(TMO)) dut (
        .i_clk_20mhz(clk),
        .i_rst_20mhz(rst),
        .i_acl_command_ready(ready),
        .i_a_cmd_valid(a_valid),
        .i_a_cmd(a_cmd),
        .i_b_cmd_valid(b_valid),
        .i_b_cmd(b_cmd),
        .o_a_cmd_done(a_done),
        .o_b_cmd_done(b_done),
        .o_a_cmd_err(a_err),
        .o_b_cmd_err(b_err),
        .o_acl_cmd_init_measur_mode(l_im),
        .o_acl_cmd_start_measur_mode(l_sm),
        .o_acl_cmd_init_linked_mode(l_il),
        .o_acl_cmd_start_linked_mode(l_sl),
        .o_acl_cmd_soft_reset(l_sr),
        .o_grant_b(grant_b),
        .o_busy(busy),
        .o_timeout_err(tmo_err)
    );

    always #25 clk = ~clk;

    // {soft, start_lnk, init_lnk, start_meas, init_meas, a_done, b_done, a_err, b_err, busy, grant_b, tmo}
    function automatic logic [11:0] obs();
        return {l_sr, l_sl, l_il, l_sm, l_im, a_done, b_done, a_err, b_err, busy, grant_b, tmo_err};
    endfunction

    function automatic logic [4:0] lvl_vec(input logic [2:0] code);
        logic [4:0] one;
        one = 5'd1;
        return one << (code - 3'd1);
    endfunction

    function automatic bit pick_b(input bit av, input logic [2:0] ac, input bit bv, input logic [2:0] bc, input bit last_b);
        int ra, rb;
        ra = !av ? 0 : (ac == 3'd5) ? 2 : 1;
        rb = !bv ? 0 : (bc == 3'd5) ? 2 : 1;
        if (ra != rb) return rb > ra;
        return !last_b;
    endfunction

    // From the driver's ready profile rdy[t] (t = cycles after grant), derive when
    // the level ends, when done pulses, and whether the watchdog fires.
    function automatic void predict(input logic [2:0] code, output int lvl_last, output int done_t,
                                    output bit err, output bit tmo, output int tmo_t);
        int a, b, c;
        err = 0; tmo = 0; tmo_t = 0; lvl_last = 0; done_t = 1;
        if (code == 3'd0 || code > 3'd5) begin
            err = 1;
            return;
        end
        if (code == 3'd5) begin
            a = 0;
            for (int t = 2; t <= TMO; t++) if (rdy[t] && a == 0) a = t;
            if (a != 0) begin
                lvl_last = a; done_t = a + 1;
                return;
            end
            lvl_last = TMO; tmo = 1; err = 1; tmo_t = TMO + 1;
            c = 0;
            for (int t = TMO + 1; t < 63; t++) if (rdy[t] && c == 0) c = t;
            done_t = c + 1;
            return;
        end
        a = 0;
        for (int t = 1; t <= TMO; t++) if (!rdy[t] && a == 0) a = t;
        if (a == 0) begin
            lvl_last = TMO; tmo = 1; err = 1; tmo_t = TMO + 1; done_t = TMO + 1;
            return;
        end
        lvl_last = a;
        b = 0;
        for (int t = a + 1; t <= a + TMO; t++) if (rdy[t] && b == 0) b = t;
        if (b != 0) begin
            done_t = b + 1;
            return;
        end
        tmo = 1; err = 1; tmo_t = a + TMO + 1;
        c = 0;
        for (int t = a + TMO + 1; t < 63; t++) if (rdy[t] && c == 0) c = t;
        done_t = c + 1;
    endfunction

    // Serve every pending request. mode: 0 random driver delays, 1 drop after 3 / raise after 10,
    // 2 ready never drops, 3 ready stuck low past the watchdog.
    task automatic serve(input bit av, input logic [2:0] ac, input bit bv, input logic [2:0] bc, input int mode);
        bit pa, pb, wb, err, tmo;
        logic [2:0] code;
        int d1, d2, lvl_last, done_t, tmo_t, guard;
        logic [11:0] exp;
        pa = av; pb = bv; guard = 0;
        a_valid = pa; a_cmd = ac; b_valid = pb; b_cmd = bc; ready = 1'b1;
        while ((pa || pb) && guard < 4) begin
            guard++;
            wb = pick_b(pa, ac, pb, bc, ref_last_b);
            code = wb ? bc : ac;
            ref_last_b = wb;
            d1 = (mode == 1) ? 3 : $urandom_range(0, 4);
            d2 = (mode == 1) ? 10 : (mode == 3) ? TMO + $urandom_range(0, 5) : $urandom_range(1, 8);
            for (int i = 0; i < 64; i++)
                rdy[i] = (mode == 2) || code == 3'd0 || code > 3'd5 || !(i >= 1 + d1 && i < 1 + d1 + d2);
            predict(code, lvl_last, done_t, err, tmo, tmo_t);
            for (int t = 1; t <= done_t; t++) begin
                @(negedge clk);
                exp = {(t <= lvl_last) ? lvl_vec(code) : 5'b0,
                       t == done_t && !wb, t == done_t && wb,
                       t == done_t && !wb && err, t == done_t && wb && err,
                       1'b1, wb, ref_tmo || (tmo && t >= tmo_t)};
                total++;
                if (obs() !== exp) begin
                    bad++;
                    $display("FAIL serve code=%0d b=%0b t=%0d got=%03h exp=%03h", code, wb, t, obs(), exp);
                end
                ready = rdy[t];
                if (t == done_t) begin
                    if (wb) pb = 0; else pa = 0;
                    a_valid = pa; b_valid = pb;
                end
            end
            ref_tmo = ref_tmo || tmo;
            ref_grant = wb;
            @(negedge clk);
            exp = {9'b0, 1'b0, ref_grant, ref_tmo};
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL idle_after_done got=%03h exp=%03h", obs(), exp);
            end
        end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs() !== 12'h000) begin bad++; $display("FAIL reset_hold got=%03h exp=000", obs()); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (obs() !== 12'h000) begin bad++; $display("FAIL reset_release got=%03h exp=000", obs()); end
    endtask

    task automatic test_single();
        serve(1, 3'd1, 0, 3'd0, 1);
        serve(0, 3'd0, 1, 3'($urandom_range(1, 4)), 0);
    endtask

    task automatic test_back_to_back();
        serve(1, 3'd2, 1, 3'd4, 0);
    endtask

    task automatic test_soft_reset_priority();
        serve(1, 3'd3, 1, 3'd5, 0);
        serve(1, 3'd5, 0, 3'd0, 0);
    endtask

    task automatic test_invalid();
        serve(0, 3'd0, 1, 3'd7, 0);
        serve(1, 3'd1, 1, 3'd3, 0);
        serve(1, 3'd0, 0, 3'd0, 0);
    endtask

    task automatic test_timeout();
        serve(1, 3'($urandom_range(1, 4)), 0, 3'd0, 2);
        serve(0, 3'd0, 1, 3'($urandom_range(1, 4)), 3);
    endtask

    task automatic test_idle_gating();
        logic [11:0] exp;
        b_valid = 1; b_cmd = 3'd2; ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) b_valid = 0;
        end
        a_valid = 1; a_cmd = 3'd3;
        for (int i = 0; i < TMO + 6; i++) begin
            @(negedge clk);
            if (i == TMO + 2) begin a_valid = 0; ready = 1; end
            exp = {9'b0, 1'b0, ref_grant, ref_tmo};
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL idle_gating i=%0d got=%03h exp=%03h", i, obs(), exp); end
        end
        serve(1, 3'd3, 0, 3'd0, 0);
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp;
        serve(1, 3'd2, 0, 3'd0, 0);
        a_valid = 1; a_cmd = 3'd2; ready = 1;
        @(negedge clk);
        exp = {lvl_vec(3'd2), 4'b0, 1'b1, 1'b0, ref_tmo};
        total++;
        if (obs() !== exp) begin bad++; $display("FAIL mid_issue got=%03h exp=%03h", obs(), exp); end
        ready = 0;
        @(negedge clk);
        rst = 1; a_valid = 0;
        @(negedge clk);
        total++;
        if (obs() !== 12'h000) begin bad++; $display("FAIL mid_reset got=%03h exp=000", obs()); end
        rst = 0; ready = 1;
        ref_last_b = 1; ref_grant = 0; ref_tmo = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs() !== 12'h000) begin bad++; $display("FAIL post_reset i=%0d got=%03h exp=000", i, obs()); end
        end
        serve(1, 3'd1, 1, 3'd2, 0);
    endtask

    task automatic test_random();
        bit av, bv;
        for (int n = 0; n < 25; n++) begin
            av = 1'($urandom_range(0, 1));
            bv = 1'($urandom_range(0, 1));
            if (!av && !bv) av = 1;
            serve(av, 3'($urandom_range(0, 7)), bv, 3'($urandom_range(0, 7)), 0);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_soft_reset_priority();
        test_invalid();
        test_timeout();
        test_idle_gating();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
